// File: rtl/fft_pkg.sv
// Shared definitions for the SDF FFT pipeline: default length, log2 helper,
// stage-controller FSM states and the default twiddle address width.
package fft_pkg;

    localparam int N_FFT_DEFAULT = 128;

    function automatic int log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    localparam int TW_ADDR_W = log2(N_FFT_DEFAULT) - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/sdf_gap_timer.sv
// Counts idle cycles at a frame boundary; expire_o fires on the cycle the
// count reaches IDLE_GAP, and the counter restarts from zero.
module sdf_gap_timer #(
    parameter int IDLE_GAP = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic expire_o
);

    localparam int GW = $clog2(IDLE_GAP + 1);

    logic [GW-1:0] gap_q, gap_d;
    logic [GW-1:0] gap_inc;

    always_comb begin
        gap_inc  = gap_q + 1'b1;
        expire_o = inc_i && (gap_inc == GW'(IDLE_GAP));
        gap_d    = gap_q;
        if (clr_i || expire_o) begin
            gap_d = '0;
        end else if (inc_i) begin
            gap_d = gap_inc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gap_q <= '0;
        end else begin
            gap_q <= gap_d;
        end
    end

endmodule

// File: rtl/sdf_stage_ctrl.sv
// Sequencing controller for one radix-2 SDF FFT stage, delay D = N_FFT >> (STAGE+1).
// Define SOP_CHECK_EN to flag and resynchronise on a misaligned in_sop; otherwise err_sop is tied 0.
module sdf_stage_ctrl
    import fft_pkg::*;
#(
    parameter int N_FFT    = N_FFT_DEFAULT,
    parameter int STAGE    = 0,
    parameter int IDLE_GAP = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    input  logic                   in_sop,
    output logic                   sr_valid,
    output logic                   bf_sel,
    output logic [log2(N_FFT)-2:0] tw_addr,
    output logic                   out_valid,
    output logic                   out_sop,
    output logic                   busy,
    output logic                   err_sop
);

    localparam int W   = log2(N_FFT);
    localparam int AW  = W - 1;
    localparam int D   = N_FFT >> (STAGE + 1);
    localparam int DW  = log2(D);
    localparam int DCW = (DW > 0) ? DW : 1;

    state_e         state_q, state_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic [DCW-1:0] dcnt_q, dcnt_d;
    logic           primed_q, primed_d;
    logic [AW-1:0]  tw_q, tw_d;

    logic           sr_c, bf_c, ov_c, sop_c, err_c;
    logic           gap_clr, gap_inc, gap_expire;
    logic [W-1:0]   k;

    // Idle cycles only count while parked exactly on a frame boundary.
    assign gap_clr = (state_q != RUN) || in_valid;
    assign gap_inc = (state_q == RUN) && !in_valid && (cnt_q == '0);

    sdf_gap_timer #(
        .IDLE_GAP (IDLE_GAP)
    ) u_gap (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr_i    (gap_clr),
        .inc_i    (gap_inc),
        .expire_o (gap_expire)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dcnt_d   = dcnt_q;
        primed_d = primed_q;
        sr_c     = 1'b0;
        bf_c     = 1'b0;
        ov_c     = 1'b0;
        err_c    = 1'b0;

        case (state_q)
            IDLE: begin
                sr_c = in_valid && in_sop;
                if (sr_c) begin
                    cnt_d   = W'(1);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (in_valid) begin
                    sr_c  = 1'b1;
                    bf_c  = cnt_q[DW];
                    cnt_d = cnt_q + 1'b1;
                    if (bf_c) primed_d = 1'b1;
`ifdef SOP_CHECK_EN
                    if (in_sop && (cnt_q != '0)) begin
                        err_c    = 1'b1;
                        bf_c     = 1'b0;
                        cnt_d    = W'(1);
                        primed_d = 1'b0;
                    end
`endif
                    ov_c = bf_c || (primed_q && !err_c);
                end else if (gap_expire) begin
                    state_d = DRAIN;
                    dcnt_d  = '0;
                end
            end
            DRAIN: begin
                sr_c   = 1'b1;
                ov_c   = primed_q;
                dcnt_d = dcnt_q + 1'b1;
                if (dcnt_q == DCW'(D - 1)) begin
                    state_d  = IDLE;
                    primed_d = 1'b0;
                    cnt_d    = '0;
                    dcnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Twiddle index only matters for difference outputs; hold it otherwise.
    always_comb begin
        k     = (state_q == DRAIN) ? W'(dcnt_q) : (cnt_q & W'(D - 1));
        tw_d  = (ov_c && !bf_c) ? AW'(k << STAGE) : tw_q;
        sop_c = ov_c && bf_c && (cnt_q == W'(D));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            dcnt_q   <= '0;
            primed_q <= 1'b0;
            tw_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dcnt_q   <= dcnt_d;
            primed_q <= primed_d;
            tw_q     <= tw_d;
        end
    end

    assign sr_valid  = reset_n && sr_c;
    assign bf_sel    = reset_n && bf_c;
    assign out_valid = reset_n && ov_c;
    assign out_sop   = reset_n && sop_c;
    assign err_sop   = reset_n && err_c;
    assign busy      = reset_n && (state_q != IDLE);
    assign tw_addr   = reset_n ? tw_d : '0;

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Scoreboard bench for sdf_stage_ctrl: two instances (STAGE 0 and 2) share one
// randomized stimulus stream; a frame-level model predicts every delay-line shift.
module tb_sdf_stage_ctrl;

    localparam int N        = 128;
    localparam int IDLE_GAP = 4;
`ifdef SOP_CHECK_EN
    localparam bit SOPCHK = 1'b1;
`else
    localparam bit SOPCHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic       in_sop;
    logic [1:0] sr_v, bf, ov, osop, bsy, err;
    logic [5:0] tw0, tw1;

    always #5 clk = ~clk;

    sdf_stage_ctrl #(.N_FFT(N), .STAGE(0), .IDLE_GAP(IDLE_GAP)) dut0 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_sop(in_sop),
        .sr_valid(sr_v[0]), .bf_sel(bf[0]), .tw_addr(tw0), .out_valid(ov[0]),
        .out_sop(osop[0]), .busy(bsy[0]), .err_sop(err[0])
    );

    sdf_stage_ctrl #(.N_FFT(N), .STAGE(2), .IDLE_GAP(IDLE_GAP)) dut2 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_sop(in_sop),
        .sr_valid(sr_v[1]), .bf_sel(bf[1]), .tw_addr(tw1), .out_valid(ov[1]),
        .out_sop(osop[1]), .busy(bsy[1]), .err_sop(err[1])
    );

    typedef struct {
        bit         bf;
        bit         ov;
        bit         sop;
        bit         err;
        bit         twc;
        logic [5:0] tw;
    } rec_t;

    rec_t q0[$];
    rec_t q1[$];

    int checks = 0;
    int passed = 0;
    int pos[2];
    bit primed[2];
    bit active[2];
    int idle_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int stg(input int i);
        return (i == 0) ? 0 : 2;
    endfunction

    function automatic int dly(input int i);
        return N >> (stg(i) + 1);
    endfunction

    task automatic push(input int i, input rec_t r);
        if (i == 0) q0.push_back(r);
        else q1.push_back(r);
    endtask

    // One accepted sample: first half of every 2D block loads, second half computes sums;
    // once a compute half has been seen, each load half emits the stored differences.
    task automatic model_sample(input int i, input bit s);
        rec_t r;
        int   d;
        int   j;
        d = dly(i);
        r = '{default: 0};
        if (!active[i]) begin
            if (!s) return;
            active[i] = 1'b1;
            pos[i]    = 0;
        end
        if (SOPCHK && s && pos[i] != 0) begin
            r.err     = 1'b1;
            pos[i]    = 1;
            primed[i] = 1'b0;
            push(i, r);
            return;
        end
        j     = pos[i];
        r.bf  = ((j / d) % 2) == 1;
        r.ov  = r.bf || primed[i];
        r.sop = r.bf && (j == d);
        r.twc = r.ov && !r.bf;
        r.tw  = 6'((j % d) << stg(i));
        if (r.bf) primed[i] = 1'b1;
        pos[i] = (j + 1) % N;
        push(i, r);
    endtask

    task automatic model_drain(input int i);
        rec_t r;
        for (int k = 0; k < dly(i); k++) begin
            r     = '{default: 0};
            r.ov  = primed[i];
            r.twc = primed[i];
            r.tw  = 6'(k << stg(i));
            push(i, r);
        end
        primed[i] = 1'b0;
        active[i] = 1'b0;
        pos[i]    = 0;
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        for (int i = 0; i < 2; i++) begin
            pos[i]    = 0;
            primed[i] = 1'b0;
            active[i] = 1'b0;
        end
        idle_cnt = 0;
    endtask

    task automatic drive(input bit v, input bit s);
        @(posedge clk);
        #1;
        in_valid = v;
        in_sop   = s;
        if (v) begin
            idle_cnt = 0;
            model_sample(0, s);
            model_sample(1, s);
        end else if (active[0] && pos[0] == 0) begin
            idle_cnt++;
            if (idle_cnt == IDLE_GAP) begin
                idle_cnt = 0;
                model_drain(0);
                model_drain(1);
            end
        end
    endtask

    // Drive one frame (sop first, optional extra sop at index sop_at) until both
    // models sit on a frame boundary again; bubbles only ever occur mid-frame.
    task automatic frame(input int bubble_pct, input int sop_at);
        int j;
        j = 0;
        drive(1'b1, 1'b1);
        j++;
        while (!(pos[0] == 0 && pos[1] == 0) && j < 400) begin
            for (int b = 0; b < 3; b++) begin
                if ($urandom_range(99) < bubble_pct) drive(1'b0, 1'b0);
            end
            drive(1'b1, j == sop_at);
            j++;
        end
        chk("frame_len_bound", j < 400, 1);
    endtask

    task automatic wait_done(input int seen0, input int seen1);
        int n0, n1, cyc;
        n0  = seen0;
        n1  = seen1;
        cyc = 0;
        do begin
            drive(1'b0, 1'b0);
            @(negedge clk);
            n0 += int'(sr_v[0]);
            n1 += int'(sr_v[1]);
            cyc++;
        end while (bsy != 2'b00 && cyc < 200);
        chk("drain_timeout", cyc < 200, 1);
        chk("drain_len_d0", n0, 64);
        chk("drain_len_d2", n1, 16);
        chk("busy_after_drain", bsy, 0);
        chk("q0_empty", q0.size(), 0);
        chk("q1_empty", q1.size(), 0);
    endtask

    task automatic mon(input int i);
        rec_t       r;
        logic [5:0] t;
        t = (i == 0) ? tw0 : tw1;
        if (sr_v[i]) begin
            if ((i == 0 ? q0.size() : q1.size()) == 0) begin
                chk($sformatf("d%0d_unexpected_shift", i), 1, 0);
            end else begin
                r = (i == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("d%0d_bf_sel", i), bf[i], r.bf);
                chk($sformatf("d%0d_out_valid", i), ov[i], r.ov);
                chk($sformatf("d%0d_out_sop", i), osop[i], r.sop);
                chk($sformatf("d%0d_err_sop", i), err[i], r.err);
                if (r.twc) chk($sformatf("d%0d_tw_addr", i), t, r.tw);
            end
        end else begin
            chk($sformatf("d%0d_quiet_outs", i), {ov[i], osop[i], err[i]}, 0);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            mon(0);
            mon(1);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        model_reset();
        reset_n  = 1'b0;
        in_valid = 1'b1;
        in_sop   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sr_valid", sr_v, 0);
        chk("rst_bf_sel", bf, 0);
        chk("rst_out_valid", ov, 0);
        chk("rst_out_sop", osop, 0);
        chk("rst_busy", bsy, 0);
        chk("rst_err_sop", err, 0);
        chk("rst_tw_addr", {tw1, tw0}, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        reset_n  = 1'b1;

        // Single frame, then the exact idle-gap timing into DRAIN.
        frame(0, -1);
        for (int c = 1; c <= IDLE_GAP; c++) begin
            drive(1'b0, 1'b0);
            @(negedge clk);
            chk("gap_no_shift", sr_v, 0);
            chk("gap_busy", bsy, 2'b11);
        end
        drive(1'b0, 1'b0);
        @(negedge clk);
        chk("drain_start", sr_v, 2'b11);
        wait_done(1, 1);

        // Back-to-back frames, then a short boundary gap that must not drain.
        frame(0, -1);
        frame(0, -1);
        @(negedge clk);
        chk("continuous_busy", bsy, 2'b11);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        frame(0, -1);
        wait_done(0, 0);

        // Random mid-frame bubbles.
        frame(50, -1);
        frame(30, -1);
        wait_done(0, 0);

        // Misaligned sop at index 37.
        frame(0, 37);
        wait_done(0, 0);

        // Reset during drain, then a clean restart.
        frame(0, -1);
        dc = 0;
        for (int c = 0; c < 60 && dc < 10; c++) begin
            drive(1'b0, 1'b0);
            @(negedge clk);
            if (sr_v[0]) dc++;
        end
        chk("reached_drain_10", dc, 10);
        @(posedge clk);
        #1;
        reset_n  = 1'b0;
        in_valid = 1'b1;
        in_sop   = 1'b1;
        model_reset();
        #1;
        chk("midrst_sr_valid", sr_v, 0);
        chk("midrst_out_valid", ov, 0);
        chk("midrst_busy", bsy, 0);
        chk("midrst_tw_addr", {tw1, tw0}, 0);
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        reset_n  = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", bsy, 0);
        frame(0, -1);
        wait_done(0, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
